// File: rtl/r4_pkg.sv
// Shared types and default widths for the radix-4 butterfly family.
// Used by both the forward and inverse butterflies.
package r4_pkg;

  localparam int R4_W  = 4;
  localparam int R4_OW = R4_W + 2;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } r4_state_e;

  typedef logic [1:0] r4_idx_t;

endpackage

// File: rtl/r4_ibfly_core.sv
// Combinational radix-4 inverse DFT kernel: y[n] = sum_k x[k]*(+j)^(n*k).
// Samples are packed flat, slot k in bits [k*W +: W]; optional 1/N scaling by floor shift.
module r4_ibfly_core
  import r4_pkg::*;
#(
  parameter int W     = R4_W,
  parameter int SCALE = 0
) (
  input  logic [4*W-1:0]     x_re_i,
  input  logic [4*W-1:0]     x_im_i,
  output logic [4*(W+2)-1:0] y_re_o,
  output logic [4*(W+2)-1:0] y_im_o
);

  localparam int OW = W + 2;

  logic signed [OW-1:0] xr_s [4];
  logic signed [OW-1:0] xi_s [4];
  logic signed [OW-1:0] tr_s [4];
  logic signed [OW-1:0] ti_s [4];
  logic signed [OW-1:0] yr_s [4];
  logic signed [OW-1:0] yi_s [4];

  // Butterfly arithmetic; OW = W+2 bits holds the worst-case sum of four samples.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      xr_s[k] = {{2{x_re_i[k*W+W-1]}}, x_re_i[k*W +: W]};
      xi_s[k] = {{2{x_im_i[k*W+W-1]}}, x_im_i[k*W +: W]};
    end
    tr_s[0] = xr_s[0] + xr_s[2];
    ti_s[0] = xi_s[0] + xi_s[2];
    tr_s[1] = xr_s[0] - xr_s[2];
    ti_s[1] = xi_s[0] - xi_s[2];
    tr_s[2] = xr_s[1] + xr_s[3];
    ti_s[2] = xi_s[1] + xi_s[3];
    tr_s[3] = xr_s[1] - xr_s[3];
    ti_s[3] = xi_s[1] - xi_s[3];
    yr_s[0] = tr_s[0] + tr_s[2];
    yi_s[0] = ti_s[0] + ti_s[2];
    yr_s[2] = tr_s[0] - tr_s[2];
    yi_s[2] = ti_s[0] - ti_s[2];
    // Multiplying t3 by +j swaps components and negates the new real part.
    yr_s[1] = tr_s[1] - ti_s[3];
    yi_s[1] = ti_s[1] + tr_s[3];
    yr_s[3] = tr_s[1] + ti_s[3];
    yi_s[3] = ti_s[1] - tr_s[3];
  end

  // Output packing with optional arithmetic >>>2 scaling.
  always_comb begin
    y_re_o = '0;
    y_im_o = '0;
    for (int k = 0; k < 4; k++) begin
      if (SCALE != 0) begin
        y_re_o[k*OW +: OW] = yr_s[k] >>> 2;
        y_im_o[k*OW +: OW] = yi_s[k] >>> 2;
      end else begin
        y_re_o[k*OW +: OW] = yr_s[k];
        y_im_o[k*OW +: OW] = yi_s[k];
      end
    end
  end

endmodule

// File: rtl/r4_ibutter_seq.sv
// Sequential radix-4 inverse butterfly: serial load of 4 samples, one compute cycle,
// serial drain of 4 results with backpressure. All outputs are registered.
module r4_ibutter_seq
  import r4_pkg::*;
#(
  parameter int W     = R4_W,
  parameter int SCALE = 0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W+1:0] out_re,
  output logic [W+1:0] out_im,
  output logic [1:0]   out_idx,
  output logic         busy
);

  localparam int OW = W + 2;

  r4_state_e         state_q, state_d;
  r4_idx_t           cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [OW-1:0]     out_re_q, out_re_d;
  logic [OW-1:0]     out_im_q, out_im_d;
  r4_idx_t           out_idx_q, out_idx_d;
  logic              busy_q, busy_d;
  logic [4*W-1:0]    x_re_q, x_im_q;
  logic [4*OW-1:0]   y_re_q, y_im_q;
  logic [4*OW-1:0]   core_re_s, core_im_s;
  logic              load_fire_s;
  r4_idx_t           nxt_idx_s;

  assign load_fire_s = in_valid & in_ready_q;
  assign nxt_idx_s   = cnt_q + 2'd1;

  r4_ibfly_core #(.W(W), .SCALE(SCALE)) u_core (
    .x_re_i (x_re_q),
    .x_im_i (x_im_q),
    .y_re_o (core_re_s),
    .y_im_o (core_im_s)
  );

  // Next-state and registered-output logic; outputs of the drain stage are loaded from the result regs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_idx_d   = out_idx_q;
    busy_d      = busy_q;
    case (state_q)
      LOAD: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (load_fire_s) begin
          if (cnt_q == 2'd3) begin
            state_d    = COMPUTE;
            cnt_d      = 2'd0;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
          end else begin
            cnt_d = nxt_idx_s;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      COMPUTE: begin
        state_d     = DRAIN;
        cnt_d       = 2'd0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b1;
      end
      DRAIN: begin
        // First DRAIN cycle primes the output register with y0.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_idx_d   = cnt_q;
          out_re_d    = y_re_q[int'(cnt_q)*OW +: OW];
          out_im_d    = y_im_q[int'(cnt_q)*OW +: OW];
        end else if (out_ready) begin
          if (cnt_q == 2'd3) begin
            state_d     = LOAD;
            cnt_d       = 2'd0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
          end else begin
            cnt_d     = nxt_idx_s;
            out_idx_d = nxt_idx_s;
            out_re_d  = y_re_q[int'(nxt_idx_s)*OW +: OW];
            out_im_d  = y_im_q[int'(nxt_idx_s)*OW +: OW];
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d     = LOAD;
        cnt_d       = 2'd0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= LOAD;
      cnt_q       <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= busy_d;
    end
  end

  // Sample capture during LOAD and result capture in COMPUTE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      x_re_q <= '0;
      x_im_q <= '0;
      y_re_q <= '0;
      y_im_q <= '0;
    end else begin
      if (load_fire_s) begin
        x_re_q[int'(cnt_q)*W +: W] <= in_re;
        x_im_q[int'(cnt_q)*W +: W] <= in_im;
      end
      if (state_q == COMPUTE) begin
        y_re_q <= core_re_s;
        y_im_q <= core_im_s;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_r4_ibutter_seq.sv
// Directed bench for r4_ibutter_seq: an unscaled and a scaled instance share one input stream.
module tb_r4_ibutter_seq;

  logic       clk, rst_n;
  logic       in_valid, out_ready;
  logic [3:0] in_re, in_im;
  logic       in_ready, in_ready1;
  logic       o0_valid, o1_valid, o0_busy, o1_busy;
  logic [5:0] o0_re, o0_im, o1_re, o1_im;
  logic [1:0] o0_idx, o1_idx;

  int n_tests, n_fail;
  int vr[4], vi[4], er0[4], ei0[4], er1[4], ei1[4];

  r4_ibutter_seq #(.W(4), .SCALE(0)) dut0 (
    .CLK(clk), .RST(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(o0_valid), .out_ready(out_ready),
    .out_re(o0_re), .out_im(o0_im), .out_idx(o0_idx), .busy(o0_busy));

  r4_ibutter_seq #(.W(4), .SCALE(1)) dut1 (
    .CLK(clk), .RST(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_re(in_re), .in_im(in_im), .out_valid(o1_valid), .out_ready(out_ready),
    .out_re(o1_re), .out_im(o1_im), .out_idx(o1_idx), .busy(o1_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int re, input int im);
    int c;
    c = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_re = 4'(re);
    in_im = 4'(im);
    while (!in_ready && c < 30) begin
      @(negedge clk);
      c++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL push_timeout: in_ready got %0b exp 1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic load4(input bit gaps, input bit chk_lat);
    for (int k = 0; k < 4; k++) begin
      if (gaps && k != 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      push(vr[k], vi[k]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (chk_lat) begin
      n_tests++;
      if (o0_valid !== 1'b0) begin n_fail++; $display("FAIL lat_t1 out_valid got %0b exp 0", o0_valid); end
      @(negedge clk);
      n_tests++;
      if (o0_valid !== 1'b0) begin n_fail++; $display("FAIL lat_t2 out_valid got %0b exp 0", o0_valid); end
      @(negedge clk);
      n_tests++;
      if (o0_valid !== 1'b1) begin n_fail++; $display("FAIL lat_t3 out_valid got %0b exp 1", o0_valid); end
    end
  endtask

  task automatic check_out(input string nm, input int n);
    n_tests++;
    if (o0_valid !== 1'b1 || o0_idx !== 2'(n)) begin
      n_fail++; $display("FAIL %s idx: got valid=%0b idx=%0d exp valid=1 idx=%0d", nm, o0_valid, o0_idx, n);
    end
    n_tests++;
    if (o0_re !== 6'(er0[n]) || o0_im !== 6'(ei0[n])) begin
      n_fail++; $display("FAIL %s y%0d: got (%0d,%0d) exp (%0d,%0d)", nm, n, $signed(o0_re), $signed(o0_im), er0[n], ei0[n]);
    end
    n_tests++;
    if (o1_re !== 6'(er1[n]) || o1_im !== 6'(ei1[n]) || o1_idx !== 2'(n)) begin
      n_fail++; $display("FAIL %s scaled y%0d: got (%0d,%0d) idx=%0d exp (%0d,%0d)", nm, n, $signed(o1_re), $signed(o1_im), o1_idx, er1[n], ei1[n]);
    end
  endtask

  task automatic drain(input string nm);
    int c;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      c = 0;
      while (!o0_valid && c < 30) begin
        @(negedge clk);
        c++;
      end
      check_out(nm, n);
      @(negedge clk);
    end
    n_tests++;
    if (o0_valid !== 1'b0 || in_ready !== 1'b1 || o0_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s end: got valid=%0b in_ready=%0b busy=%0b exp 0,1,0", nm, o0_valid, in_ready, o0_busy);
    end
  endtask

  task automatic set_mixed();
    vr = '{1, 3, -2, 0};  vi = '{2, -1, 0, 4};
    er0 = '{2, 8, -4, -2}; ei0 = '{5, 5, -1, -1};
    er1 = '{0, 2, -1, -1}; ei1 = '{1, 1, -1, -1};
  endtask

  task automatic set_impulse();
    vr = '{1, 0, 0, 0};  vi = '{0, 0, 0, 0};
    er0 = '{1, 1, 1, 1}; ei0 = '{0, 0, 0, 0};
    er1 = '{0, 0, 0, 0}; ei1 = '{0, 0, 0, 0};
  endtask

  task automatic set_shift();
    vr = '{0, 1, 0, 0};   vi = '{0, 0, 0, 0};
    er0 = '{1, 0, -1, 0}; ei0 = '{0, 1, 0, -1};
    er1 = '{0, 0, -1, 0}; ei1 = '{0, 0, 0, -1};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || o0_valid !== 1'b0 || o0_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: got in_ready=%0b valid=%0b busy=%0b exp 0", in_ready, o0_valid, o0_busy);
    end
    n_tests++;
    if (o0_re !== 6'd0 || o0_im !== 6'd0 || o0_idx !== 2'd0) begin
      n_fail++; $display("FAIL reset_data: got re=%0d im=%0d idx=%0d exp 0", o0_re, o0_im, o0_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || o0_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got in_ready=%0b busy=%0b exp 1,0", in_ready, o0_busy);
    end
  endtask

  task automatic test_impulse();
    set_impulse();
    load4(1'b0, 1'b1);
    drain("impulse");
  endtask

  task automatic test_shift();
    set_shift();
    load4(1'b0, 1'b0);
    drain("shift");
  endtask

  task automatic test_extreme();
    vr = '{-8, -8, -8, -8};  vi = '{-8, -8, -8, -8};
    er0 = '{-32, 0, 0, 0};   ei0 = '{-32, 0, 0, 0};
    er1 = '{-8, 0, 0, 0};    ei1 = '{-8, 0, 0, 0};
    load4(1'b0, 1'b0);
    drain("extreme");
  endtask

  task automatic test_gaps();
    set_mixed();
    load4(1'b0, 1'b0);
    drain("gapfree");
    load4(1'b1, 1'b1);
    drain("gaps");
  endtask

  task automatic test_backpressure();
    int c;
    set_mixed();
    out_ready = 1'b0;
    load4(1'b0, 1'b0);
    c = 0;
    while (!o0_valid && c < 30) begin
      @(negedge clk);
      c++;
    end
    check_out("bp", 0);
    out_ready = 1'b1;
    @(negedge clk);
    check_out("bp", 1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_re = 4'(7);
    in_im = 4'(7);
    repeat (3) begin
      @(negedge clk);
      check_out("bp_hold", 1);
      n_tests++;
      if (in_ready !== 1'b0 || o0_busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_in_ready: got in_ready=%0b busy=%0b exp 0,1", in_ready, o0_busy);
      end
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_out("bp", 2);
    @(negedge clk);
    check_out("bp", 3);
    @(negedge clk);
    n_tests++;
    if (o0_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_end: got valid=%0b in_ready=%0b exp 0,1", o0_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    set_shift();
    load4(1'b0, 1'b0);
    drain("b2b_a");
    set_impulse();
    load4(1'b0, 1'b0);
    drain("b2b_b");
  endtask

  task automatic test_reset_mid_drain();
    int c;
    set_mixed();
    out_ready = 1'b1;
    load4(1'b0, 1'b0);
    c = 0;
    while (!(o0_valid && o0_idx == 2'd2) && c < 30) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (o0_idx !== 2'd2 || o0_valid !== 1'b1) begin
      n_fail++; $display("FAIL rmd_reach: got idx=%0d valid=%0b exp 2,1", o0_idx, o0_valid);
    end
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (o0_valid !== 1'b0 || in_ready !== 1'b0 || o0_busy !== 1'b0) begin
      n_fail++; $display("FAIL rmd_async: got valid=%0b in_ready=%0b busy=%0b exp 0", o0_valid, in_ready, o0_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmd_release: in_ready got %0b exp 1", in_ready);
    end
    set_shift();
    load4(1'b0, 1'b1);
    drain("rmd_after");
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_re = 4'd0;
    in_im = 4'd0;
    rst_n = 1'b0;
    test_reset();
    test_impulse();
    test_shift();
    test_extreme();
    test_gaps();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
